// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared pipeline-control types and constants
package core_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = W'(1);

  // Clear beats increment; the counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, branch flush and memory-wait freeze control
module hazard_unit
  import core_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_IR1,
  input  logic [4:0]       rs2_IR1,
  input  logic             uses_rs1_IR1,
  input  logic             uses_rs2_IR1,
  input  logic             MemRead_IR2,
  input  logic [4:0]       instb_IR2,
  input  logic             branch_taken_IR3,
  input  logic             dmem_busy,
  input  logic             perf_clr,
  output logic             pc_write,
  output logic             ir1_write,
  output logic             bubble_IR2,
  output logic             flush_IR1,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

  hz_state_e  state_q, state_d;
  logic [1:0] stall_left_q, stall_left_d;
  logic       lu_hazard;
  logic       flush_evt;

  assign lu_hazard = MemRead_IR2 && (instb_IR2 != REG_ZERO) &&
                     ((uses_rs1_IR1 && (rs1_IR1 == instb_IR2)) ||
                      (uses_rs2_IR1 && (rs2_IR1 == instb_IR2)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      stall_left_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      stall_left_q <= stall_left_d;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    ir1_write    = 1'b1;
    bubble_IR2   = 1'b0;
    flush_IR1    = 1'b0;
    freeze       = 1'b0;
    flush_evt    = 1'b0;
    state_d      = state_q;
    stall_left_d = stall_left_q;

    if (!rst_n) begin
      pc_write     = 1'b0;
      ir1_write    = 1'b0;
      freeze       = 1'b1;
      state_d      = RUN;
      stall_left_d = 2'd0;
    end else if (dmem_busy) begin
      pc_write  = 1'b0;
      ir1_write = 1'b0;
      freeze    = 1'b1;
    end else if (branch_taken_IR3) begin
      // Wrong-path work in IF/ID and ID/EX is discarded; any pending stall is moot.
      flush_IR1  = 1'b1;
      bubble_IR2 = 1'b1;
      flush_evt  = 1'b1;
      state_d    = RUN;
    end else if (state_q == LU_STALL) begin
      pc_write   = 1'b0;
      ir1_write  = 1'b0;
      bubble_IR2 = 1'b1;
      if (stall_left_q == 2'd1) begin
        state_d = RUN;
      end else begin
        stall_left_d = stall_left_q - 2'd1;
      end
    end else if (lu_hazard) begin
      pc_write   = 1'b0;
      ir1_write  = 1'b0;
      bubble_IR2 = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        state_d      = LU_STALL;
        stall_left_d = STALL_INIT;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (!pc_write),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (flush_evt),
    .cnt   (flush_cnt)
  );

endmodule
